// File: rtl/button_event_if.sv
// Debounced button inputs and gesture event outputs shared between the
// debouncer side (master) and the gesture classifier (slave).
interface button_event_if;
  logic db_level;
  logic db_tick;
  logic click_tick;
  logic dclick_tick;
  logic long_tick;
  logic repeat_tick;
  logic busy;

  modport master (
    output db_level,
    output db_tick,
    input  click_tick,
    input  dclick_tick,
    input  long_tick,
    input  repeat_tick,
    input  busy
  );

  modport slave (
    input  db_level,
    input  db_tick,
    output click_tick,
    output dclick_tick,
    output long_tick,
    output repeat_tick,
    output busy
  );
endinterface

// File: rtl/button_event.sv
// Gesture classifier: turns debounced presses into single-cycle click,
// double-click, long-press and auto-repeat events using one shared counter.
module button_event #(
  parameter int CNT_WIDTH     = 26,
  parameter int LONG_CYCLES   = 50000000,
  parameter int DCLICK_CYCLES = 15000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic          clk,
  input  logic          reset,
  button_event_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_LONG   = 3'd3,
    S_PRESS2 = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DCLICK_LAST = CNT_WIDTH'(DCLICK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  // tick vector order: {repeat, long, dclick, click}
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lvl_q, lvl_d;
  logic [3:0]           tick_q, tick_d;

  logic press;
  logic rel;

  assign press = bus.db_tick;
  assign rel   = lvl_q & ~bus.db_level;
  assign lvl_d = bus.db_level;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    tick_d  = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (press) begin
          state_d = S_PRESS1;
        end
      end
      S_PRESS1: begin
        // A release on the threshold cycle is still a short press.
        if (rel) begin
          state_d = S_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d   = S_LONG;
          cnt_d     = '0;
          tick_d[2] = 1'b1;
        end
      end
      S_LONG: begin
        if (rel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d     = '0;
          tick_d[3] = 1'b1;
        end
      end
      S_WAIT2: begin
        // A second press on the timeout cycle still counts as a double click.
        if (press) begin
          state_d   = S_PRESS2;
          cnt_d     = '0;
          tick_d[1] = 1'b1;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          tick_d[0] = 1'b1;
        end
      end
      S_PRESS2: begin
        cnt_d = '0;
        if (rel) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.click_tick  = tick_q[0];
    bus.dclick_tick = tick_q[1];
    bus.long_tick   = tick_q[2];
    bus.repeat_tick = tick_q[3];
    bus.busy        = (state_q != S_IDLE);
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Gesture classifier that sits directly downstream of the switch debouncer and consumes its debounced level (db_level) and its rising-edge pulse (db_tick).
- Turns each press into exactly one of four single-cycle events: click, double-click, long-press, or auto-repeat while held.
- Feeds the UI/control logic (mode select, counter increment) so that consumers never time buttons themselves.

Parameters:
- CNT_WIDTH, 26, width of the shared interval counter; must satisfy 2^CNT_WIDTH > max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES).
- LONG_CYCLES, 50000000, hold duration, in clk cycles after the press, that qualifies a long press; must be >= 2.
- DCLICK_CYCLES, 15000000, window after a release in which a second press makes a double-click; must be >= 2.
- REPEAT_CYCLES, 10000000, auto-repeat period once long press is active; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- db_level  in  1  debounced switch level.
- db_tick  in  1  one-cycle pulse on debounced 0->1 transition.
- click_tick  out  1  one-cycle pulse: single click.
- dclick_tick  out  1  one-cycle pulse: double click.
- long_tick  out  1  one-cycle pulse: long press reached.
- repeat_tick  out  1  one-cycle pulse: auto-repeat while held past long.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, cnt=0, lvl_q=0, all tick outputs 0. A reset mid-gesture discards the gesture; no tick is emitted for it.
- Event definitions:
  - lvl_q is db_level registered every cycle.
  - press = db_tick.
  - rel = lvl_q & ~db_level.
  - db_level high with no db_tick (e.g. held through reset) is not a press and is ignored.
- Tick outputs are registered:
  - A decision taken at edge E drives its tick high for the cycle between E and E+1.
  - Each tick lasts exactly one cycle; at most one tick is high per cycle.
- busy is combinational: high whenever state != IDLE.
- FSM states and transitions; "edge X" means the state/cnt update made at posedge X:
  - IDLE: cnt held at 0.
    - press at edge P -> PRESS1, cnt=0.
  - PRESS1: cnt+1 per cycle.
    - rel -> WAIT2, cnt=0.
    - Otherwise, if cnt==LONG_CYCLES-1 -> LONG, cnt=0, long_tick=1. This occurs at edge P+LONG_CYCLES.
    - rel in the same cycle as the threshold: rel wins; no long_tick.
  - LONG: cnt+1 per cycle.
    - When cnt==REPEAT_CYCLES-1: repeat_tick=1, cnt=0. First repeat is at edge P+LONG_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES.
    - rel -> IDLE with no further tick, and no repeat in that cycle.
  - WAIT2 (entered at edge E): cnt+1 per cycle.
    - press -> PRESS2, dclick_tick=1.
    - Otherwise, if cnt==DCLICK_CYCLES-1 -> IDLE, click_tick=1. This occurs at edge E+DCLICK_CYCLES.
    - press in the same cycle as the timeout: press wins; dclick_tick only.
  - PRESS2: no timing and no long detection.
    - rel -> IDLE with no tick.
    - A third press cannot occur before rel.
- Unreachable state encodings -> IDLE, cnt=0.
- Counter arithmetic: unsigned, CNT_WIDTH bits. It never wraps, because every state resets cnt before its terminal count is exceeded.
- Click latency is intentional: a single click is reported only after the double-click window expires.

Test Plan (LONG_CYCLES=20, DCLICK_CYCLES=10, REPEAT_CYCLES=5, CNT_WIDTH=8):
- Single click:
  - Stimulus: db_tick at edge 10, db_level high for edges 10-14, low at edge 15 (rel seen at edge 15).
  - Required: click_tick high only between edges 25 and 26; no other tick.
- Double click:
  - Stimulus: press at edge 10, release at edge 15, second db_tick at edge 19, release at edge 24.
  - Required: dclick_tick high between edges 19 and 20; no click_tick ever; busy low from edge 24.
- Long plus repeat:
  - Stimulus: press at edge 10, held to edge 45, release at edge 46.
  - Required: long_tick at 30, repeat_tick at 35, 40, 45; nothing after edge 46; no click_tick.
- Boundary, release at long threshold:
  - Stimulus: press at edge 10, rel at edge 30.
  - Required: no long_tick; click_tick at edge 40.
- Boundary, second press at timeout:
  - Stimulus: release at edge 15, second db_tick at edge 25.
  - Required: dclick_tick only.
- Reset mid-gesture:
  - Stimulus: reset low at edge 17 after a press at edge 10 and release at edge 15; db_level held high through reset release.
  - Required: no ticks, busy=0, state IDLE until the next db_tick.
